// File: rtl/gf180mcu_osu_sc_gp12t3v3__ro_freq_meter.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_gp12t3v3__ro_freq_meter
//
// Purpose:
//    On-die frequency meter for the ring-oscillator characterization
//    structures. The divided ring-oscillator signal is synchronized into the
//    CLK domain. Its rising edges are counted over a programmable window of
//    CLK cycles, and the count is returned through a start/done handshake.
//
// Parameters:
//    WIN_W       width of the window-length input (CLK cycles)
//    CNT_W       width of the edge accumulator and of the result
//    SYNC_STAGES number of synchronizer flops on ro_in (minimum 2)
//
// Ports:
//    CLK      in   1      sole clock, rising edge
//    RST      in   1      synchronous active-high reset
//    ro_in    in   1      divided ring-oscillator output, asynchronous to CLK
//    start    in   1      single-cycle measurement request (honoured in IDLE)
//    win_len  in   WIN_W  window length, sampled together with start
//    busy     out  1      high from the cycle after an accepted start
//                         through the DONE cycle
//    done     out  1      one-cycle pulse, count/ovf valid
//    count    out  CNT_W  result of the last completed measurement
//    ovf      out  1      last measurement saturated
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_gp12t3v3__ro_freq_meter #(
   parameter int WIN_W       = 16,
   parameter int CNT_W       = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ro_in,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_MEAS = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [WIN_W-1:0]       r_win;
   logic [CNT_W-1:0]       r_acc;
   logic                   r_sat;
   logic [CNT_W-1:0]       r_count;
   logic                   r_ovf;

   logic                   w_syncOut;
   logic                   w_edge;
   logic                   w_lastMeas;
   logic [CNT_W-1:0]       w_accNext;
   logic                   w_satNext;

   assign w_syncOut  = r_sync[SYNC_STAGES-1];
   assign w_edge     = w_syncOut & ~r_prev;
   assign w_lastMeas = (r_win == WIN_W'(1));

   // Saturating increment: an edge seen while the accumulator is already at
   // all-ones leaves the value alone and raises the saturation flag instead
   // of wrapping. The final MEAS cycle's edge is included in the result by
   // loading count from this next-value rather than from r_acc.
   always_comb begin
      w_accNext = r_acc;
      w_satNext = r_sat;
      if (w_edge) begin
         if (r_acc == {CNT_W{1'b1}}) begin
            w_satNext = 1'b1;
         end else begin
            w_accNext = r_acc + CNT_W'(1);
         end
      end
   end

   // Next-state logic. A start with a zero window skips ARM/MEAS and goes
   // straight to DONE; start in any other state is simply ignored.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nextState = (win_len != '0) ? S_ARM : S_DONE;
            end
         end
         S_ARM:  w_nextState = S_MEAS;
         S_MEAS: begin
            if (w_lastMeas) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath. The synchronizer and prev flop run in every state so edge
   // detection is continuous; the window only decides which edges count.
   // count/ovf are written solely on the edge entering DONE, so they stay
   // stable through ARM and MEAS of the following measurement.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync  <= '0;
         r_prev  <= 1'b0;
         r_win   <= '0;
         r_acc   <= '0;
         r_sat   <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], ro_in};
         r_prev <= w_syncOut;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (win_len != '0) begin
                     r_win <= win_len;
                  end else begin
                     r_acc   <= '0;
                     r_sat   <= 1'b0;
                     r_count <= '0;
                     r_ovf   <= 1'b0;
                  end
               end
            end
            S_ARM: begin
               r_acc <= '0;
               r_sat <= 1'b0;
            end
            S_MEAS: begin
               r_acc <= w_accNext;
               r_sat <= w_satNext;
               r_win <= r_win - WIN_W'(1);
               if (w_lastMeas) begin
                  r_count <= w_accNext;
                  r_ovf   <= w_satNext;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign done  = (r_state == S_DONE);
   assign count = r_count;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__ro_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_gf180mcu_osu_sc_gp12t3v3__ro_freq_meter
//
// Purpose:
//    Directed self-checking bench for the ring-oscillator frequency meter.
//    Two instances share clock, reset and the ring-oscillator stimulus: a
//    default-sized one (WIN_W=16, CNT_W=20) and a small one (WIN_W=8,
//    CNT_W=4) used to reach saturation quickly.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_gp12t3v3__ro_freq_meter;

   logic        clk;
   logic        rst;
   logic        ro;
   logic        start;
   logic [15:0] winLen;
   logic        busy;
   logic        done;
   logic [19:0] count;
   logic        ovf;

   logic        startS;
   logic [7:0]  winLenS;
   logic        busyS;
   logic        doneS;
   logic [3:0]  countS;
   logic        ovfS;

   int          compared   = 0;
   int          mismatched = 0;

   int          roPeriod   = 4;
   logic        roHold     = 1'b0;
   int          roCnt      = 0;

   gf180mcu_osu_sc_gp12t3v3__ro_freq_meter #(
      .WIN_W(16), .CNT_W(20), .SYNC_STAGES(2)
   ) dutMain (
      .CLK(clk), .RST(rst), .ro_in(ro), .start(start), .win_len(winLen),
      .busy(busy), .done(done), .count(count), .ovf(ovf)
   );

   gf180mcu_osu_sc_gp12t3v3__ro_freq_meter #(
      .WIN_W(8), .CNT_W(4), .SYNC_STAGES(2)
   ) dutSmall (
      .CLK(clk), .RST(rst), .ro_in(ro), .start(startS), .win_len(winLenS),
      .busy(busyS), .done(doneS), .count(countS), .ovf(ovfS)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Ring-oscillator stand-in: toggles every roPeriod/2 falling edges so its
   // period is roPeriod CLK cycles; roPeriod of 0 holds the level roHold.
   initial begin
      ro = 1'b0;
      forever begin
         @(negedge clk);
         if (roPeriod == 0) begin
            ro    = roHold;
            roCnt = 0;
         end else if (roCnt >= roPeriod / 2 - 1) begin
            roCnt = 0;
            ro    = ~ro;
         end else begin
            roCnt++;
         end
      end
   end

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on the main instance; returns in the ARM cycle (k+1).
   task automatic startMain(input logic [15:0] n);
      start  = 1'b1;
      winLen = n;
      tick();
      start  = 1'b0;
   endtask

   // Step until main done or budget; cyc is the cycle index after the start
   // edge (1 = the cycle right after it).
   task automatic waitDoneMain(input int budget, output int cyc);
      cyc = 1;
      while (!done && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic waitDoneSmall(input int budget, output int cyc);
      cyc = 1;
      while (!doneS && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   // Reset held 3 cycles with ro toggling, then the first cycle after release.
   task automatic test_reset();
      rst      = 1'b1;
      roPeriod = 4;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rst = 1'b0;
         tick();
         compared++;
         if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy[%0d]: got %b want 0", i, busy);
         end
         compared++;
         if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_done[%0d]: got %b want 0", i, done);
         end
         compared++;
         if (count !== 20'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count[%0d]: got %0d want 0", i, count);
         end
         compared++;
         if (ovf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ovf[%0d]: got %b want 0", i, ovf);
         end
      end
   endtask

   // Period 8, window 800: done at cycle 802, count 100 +/- 1, and count held
   // through the ARM/MEAS of the following measurement.
   task automatic test_nominal();
      int         cyc;
      logic [19:0] saved;
      bit         heldOk;
      roPeriod = 8;
      repeat (10) tick();
      startMain(16'd800);
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL nominal_busy_arm: got %b want 1", busy);
      end
      waitDoneMain(2000, cyc);
      compared++;
      if (cyc != 802) begin
         mismatched++;
         $display("[TB] FAIL nominal_latency: got %0d want 802", cyc);
      end
      compared++;
      if (count < 20'd99 || count > 20'd101) begin
         mismatched++;
         $display("[TB] FAIL nominal_count: got %0d want 99..101", count);
      end
      compared++;
      if (ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL nominal_ovf: got %b want 0", ovf);
      end
      saved = count;
      tick();
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL nominal_idle: got done=%b busy=%b want 0/0", done, busy);
      end
      startMain(16'd20);
      heldOk = (count === saved);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) heldOk = 1'b0;
         if (count !== saved) heldOk = 1'b0;
      end
      compared++;
      if (!heldOk) begin
         mismatched++;
         $display("[TB] FAIL nominal_count_held: got %0d want %0d", count, saved);
      end
      waitDoneMain(50, cyc);
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL nominal_second_done: got %b want 1", done);
      end
      tick();
   endtask

   // win_len=0: done right in the cycle after the start edge with count 0.
   task automatic test_zero_window();
      startMain(16'd0);
      compared++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL zero_done: got done=%b busy=%b want 1/1", done, busy);
      end
      compared++;
      if (count !== 20'd0 || ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL zero_count: got %0d/%b want 0/0", count, ovf);
      end
      tick();
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL zero_idle: got done=%b busy=%b want 0/0", done, busy);
      end
   endtask

   // Start pulsed at cycle 50 of a 100-cycle window is ignored: one done at
   // cycle 102 and nothing afterwards.
   task automatic test_ignored_start();
      int c;
      int dones;
      int doneCyc;
      dones   = 0;
      doneCyc = 0;
      startMain(16'd100);
      c = 1;
      while (c < 300) begin
         if (c == 50) begin
            start  = 1'b1;
            winLen = 16'd5;
         end
         tick();
         c++;
         start = 1'b0;
         if (done) begin
            dones++;
            doneCyc = c;
         end
      end
      compared++;
      if (dones != 1) begin
         mismatched++;
         $display("[TB] FAIL ignored_done_count: got %0d want 1", dones);
      end
      compared++;
      if (doneCyc != 102) begin
         mismatched++;
         $display("[TB] FAIL ignored_done_cycle: got %0d want 102", doneCyc);
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ignored_busy_end: got %b want 0", busy);
      end
   endtask

   // Small instance: 50 edges into a 4-bit counter saturate at 15 with ovf;
   // a following 8-cycle window clears ovf and counts about 2.
   task automatic test_saturation();
      int cyc;
      roPeriod = 4;
      startS   = 1'b1;
      winLenS  = 8'd200;
      tick();
      startS   = 1'b0;
      waitDoneSmall(400, cyc);
      compared++;
      if (cyc != 202) begin
         mismatched++;
         $display("[TB] FAIL sat_latency: got %0d want 202", cyc);
      end
      compared++;
      if (countS !== 4'd15) begin
         mismatched++;
         $display("[TB] FAIL sat_count: got %0d want 15", countS);
      end
      compared++;
      if (ovfS !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL sat_ovf: got %b want 1", ovfS);
      end
      tick();
      startS  = 1'b1;
      winLenS = 8'd8;
      tick();
      startS  = 1'b0;
      waitDoneSmall(50, cyc);
      compared++;
      if (cyc != 10) begin
         mismatched++;
         $display("[TB] FAIL sat2_latency: got %0d want 10", cyc);
      end
      compared++;
      if (ovfS !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL sat2_ovf: got %b want 0", ovfS);
      end
      compared++;
      if (countS > 4'd3) begin
         mismatched++;
         $display("[TB] FAIL sat2_count: got %0d want <=3", countS);
      end
      tick();
   endtask

   // Reset at MEAS cycle 50 of 100: back to idle with cleared result, no done,
   // and a fresh 40-cycle measurement completes normally.
   task automatic test_reset_mid();
      int cyc;
      int dones;
      roPeriod = 8;
      startMain(16'd100);
      cyc = 1;
      while (cyc < 51) begin
         tick();
         cyc++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrst_state: got busy=%b done=%b want 0/0", busy, done);
      end
      compared++;
      if (count !== 20'd0 || ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrst_count: got %0d/%b want 0/0", count, ovf);
      end
      dones = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (done) dones++;
      end
      compared++;
      if (dones != 0) begin
         mismatched++;
         $display("[TB] FAIL midrst_no_done: got %0d want 0", dones);
      end
      startMain(16'd40);
      waitDoneMain(100, cyc);
      compared++;
      if (cyc != 42) begin
         mismatched++;
         $display("[TB] FAIL midrst_restart_latency: got %0d want 42", cyc);
      end
      compared++;
      if (count < 20'd4 || count > 20'd6) begin
         mismatched++;
         $display("[TB] FAIL midrst_restart_count: got %0d want 4..6", count);
      end
      tick();
   endtask

   // ro stuck high, then stuck low: no edges in either 64-cycle window.
   task automatic test_stuck();
      int cyc;
      roPeriod = 0;
      roHold   = 1'b1;
      repeat (10) tick();
      startMain(16'd64);
      waitDoneMain(200, cyc);
      compared++;
      if (cyc != 66) begin
         mismatched++;
         $display("[TB] FAIL stuck1_latency: got %0d want 66", cyc);
      end
      compared++;
      if (count !== 20'd0) begin
         mismatched++;
         $display("[TB] FAIL stuck1_count: got %0d want 0", count);
      end
      tick();
      roHold = 1'b0;
      repeat (10) tick();
      startMain(16'd64);
      waitDoneMain(200, cyc);
      compared++;
      if (count !== 20'd0 || ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL stuck0_count: got %0d/%b want 0/0", count, ovf);
      end
      tick();
   endtask

   // Main sequence: run every scenario in order, then report.
   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      winLen  = 16'd0;
      startS  = 1'b0;
      winLenS = 8'd0;
      $display("[TB] starting ro_freq_meter bench");
      test_reset();
      test_nominal();
      test_zero_window();
      test_ignored_start();
      test_saturation();
      test_reset_mid();
      test_stuck();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__ro_freq_meter.md
# gf180mcu_osu_sc_gp12t3v3__ro_freq_meter

On-die frequency meter for the test chip's ring-oscillator characterization structures. A ring oscillator built from the library's inverter cells is divided down off-block and drives `ro_in`. This block synchronizes that signal into the `CLK` domain, counts its rising edges over a programmable window of `CLK` cycles, and returns the count through a start/done handshake. The result supports post-silicon extraction of per-stage inverter delay for the 12T 3.3 V library.

## Interface
- `WIN_W`, 16: width of the window-length input, in `CLK` cycles.
- `CNT_W`, 20: width of the edge accumulator and the result.
- `SYNC_STAGES`, 2: number of synchronizer flops on `ro_in`; minimum 2.

Ports:
- `CLK`  in  1  sole clock; all state updates on its rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `ro_in`  in  1  divided ring-oscillator output, asynchronous to `CLK`; its frequency must be at most f(`CLK`)/4.
- `start`  in  1  single-cycle request to begin a measurement.
- `win_len`  in  WIN_W  window length in `CLK` cycles, sampled together with `start`.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse; `count` and `ovf` are valid in that cycle.
- `count`  out  CNT_W  result of the last completed measurement; held between measurements.
- `ovf`  out  1  last measurement saturated; held with `count`.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops on `ro_in`, followed by a `prev` flop.
  - `edge` = sync_out & ~prev.
  - The synchronizer and `prev` run in every state, so edge detection is continuous.
- FSM states are IDLE, ARM, MEAS and DONE.
- IDLE:
  - `start`=1 and `win_len`≠0: load the window down-counter with `win_len` and go to ARM.
  - `start`=1 and `win_len`=0: clear the accumulator and go directly to DONE, which reports count 0 and ovf 0.
  - `start`=0: stay in IDLE.
- ARM (one cycle): clear the accumulator and the saturation flag, then go to MEAS. An `edge` in this cycle is not counted.
- MEAS: lasts exactly `win_len` cycles.
  - Each cycle, an asserted `edge` increments the accumulator.
  - The accumulator saturates at 2^CNT_W−1. An increment attempted at saturation sets the saturation flag.
  - The window counter decrements every cycle. The cycle in which it reads 1 is the last MEAS cycle, and the FSM then goes to DONE.
- DONE (one cycle):
  - `done`=1.
  - `count` ← accumulator and `ovf` ← saturation flag, both loaded at the edge entering DONE so they are visible during DONE.
  - The FSM returns to IDLE.
- `start` outside IDLE is ignored and not queued.
- `count`/`ovf` change only on entry to DONE and stay stable throughout ARM and MEAS.
- Accumulator arithmetic is unsigned CNT_W-bit with a saturating increment; it never wraps.
- RST asserted in any state, including mid-MEAS:
  - Next cycle: state IDLE, synchronizer and `prev` cleared, accumulator and window counter cleared, `count`=0, `ovf`=0.
  - No `done` is generated for the aborted measurement.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `ovf`=0.
- Start latency, with `start` sampled at edge k:
  - ARM occupies cycle k+1.
  - MEAS occupies cycles k+2 … k+1+N, where N = `win_len`.
  - `done` is high in cycle k+2+N.
  - Next `start` can be accepted at edge k+3+N.
- `win_len`=0: `done` is high in cycle k+1.
- `busy` is high for cycles k+1 … k+2+N, and 0 in IDLE.
- `ro_in` to `edge` latency is SYNC_STAGES+1 cycles.
  - The window applies to `edge` as it is seen after the synchronizer, not to `ro_in` as it arrives.
  - Count uncertainty is ±1 edge per window boundary.
- Expected result for a clean input of period P `CLK` cycles: N/P ±1.

## Test plan
- Reset check: hold RST for 3 cycles with `ro_in` toggling → `busy`=0, `done`=0, `count`=0, `ovf`=0 throughout, and for the first cycle after release.
- Nominal measurement: `ro_in` period 8 `CLK` cycles, `start` with `win_len`=800 → `done` exactly 802 cycles after the start edge, `count` ∈ {99,100,101}, `ovf`=0, and `count` held until the next DONE.
- Zero window and ignored start: `start` with `win_len`=0 → `done` the next cycle with `count`=0. Then `start` pulsed during MEAS of a 100-cycle window → exactly one `done`, and no second measurement follows.
- Saturation: parameters CNT_W=4, WIN_W=8, `ro_in` period 4, `win_len`=200 → `count`=15, `ovf`=1. Then a measurement with `win_len`=8 → `ovf` returns to 0 with `count` ≤ 3.
- Reset mid-measurement: RST asserted at MEAS cycle 50 of 100 → IDLE next cycle, `busy`=0, `count`=0, and no `done` pulse. A new start afterwards completes normally.
- Stuck input: `ro_in` held at 1 through a 64-cycle window → `count`=0. Then `ro_in` held at 0 → `count`=0.
